te_block_serializer: RTL and testbench
======================================

Name: te_block_serializer

Overview:
- Sits directly downstream of the multiple-retirement block and directly upstream of the trace encoder.
- Each cycle it accepts up to N parallel trace blocks (valid/iretire/ilastsize/itype/cause/tval/priv/iaddr) into a circular buffer.
- It replays them one block per cycle over a valid/ready handshake, so the encoder can stall without losing order.
- The upstream has no backpressure, so overflow is detected, the group is dropped whole, and the drop is reported.

Parameters:
- N, 2, max blocks offered per cycle (must match upstream N).
- DEPTH, 8, buffer capacity in single blocks; power of two, ≥ N.
- CNT_W, 16, width of the dropped-block counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of buffer, overflow flag and drop counter
- valid_i  in  N  per-slot block valid
- iretire_i  in  N×mure_pkg::IRETIRE_LEN  retired-instruction count per block
- ilastsize_i  in  N  last-instruction size per block
- itype_i  in  N×mure_pkg::ITYPE_LEN  itype per block
- cause_i  in  N×mure_pkg::CAUSE_LEN  exception/interrupt cause
- tval_i  in  N×mure_pkg::XLEN  trap value
- priv_i  in  N×mure_pkg::PRIV_LEN  privilege level
- iaddr_i  in  N×mure_pkg::XLEN  block start address
- valid_o  out  1  head block available
- ready_i  in  1  encoder accepts head block
- iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o  out  widths as the single-slot inputs  head block fields
- usage_o  out  $clog2(DEPTH)+1  blocks currently stored
- overflow_o  out  1  sticky: at least one group dropped
- dropped_o  out  CNT_W  saturating count of dropped blocks

Behaviour:
- Reset (async, rst_ni=0):
  - read/write pointers and usage cleared to 0; valid_o=0; overflow_o=0; dropped_o=0.
  - All data outputs read as 0 while valid_o=0; they are masked to 0, not stale.
- Push count k is the popcount of valid_i, range 0..N.
  - Blocks are written in ascending slot index, skipping slots with valid=0.
  - Written at consecutive write-pointer locations, modulo DEPTH.
- Pop occurs when valid_o && ready_i.
- Free-space check for the group: free = DEPTH − usage + pop.
  - A same-cycle pop frees a slot for the incoming group.
- Group accepted iff k ≤ free. The group is all-or-nothing and is never split.
- Group rejected when k > free:
  - nothing written; overflow_o set next cycle and stays set until reset or flush_i.
  - dropped_o += k, saturating at 2^CNT_W−1.
- Latency: a block written at edge t is visible on the outputs from cycle t+1.
  - Head is read combinationally from storage indexed by the read pointer.
  - No bypass from input to output.
- valid_o = (usage != 0).
- Output fields must stay stable while valid_o && !ready_i.
- ready_i with valid_o=0 has no effect.
- Pointers: $clog2(DEPTH) bits, natural wrap.
- usage_next = usage + (accepted ? k : 0) − pop. usage ranges 0..DEPTH inclusive.
- Full (usage=DEPTH):
  - valid_o=1.
  - With ready_i=1, one incoming block (k=1) is accepted; k=2 is dropped.
  - With ready_i=0, any k>0 is dropped.
- Empty with k>0: accepted (provided k ≤ DEPTH); valid_o rises the next cycle.
- flush_i is synchronous and has priority over push and pop in the same cycle.
  - Clears pointers, usage, overflow_o and dropped_o.
  - The input group in that cycle is discarded and not counted.
- Async reset mid-stream: all state returns to reset values immediately; buffered blocks are lost.
- Order guarantee: output order equals input order (cycle order, then ascending slot index).
- No block is duplicated or skipped once accepted.

Test Plan:
1. Reset with ready_i=1, then one block per cycle (valid_i=01, iaddr=0x1000,0x1004,0x1008) → valid_o high from cycle after first push; iaddr_o 0x1000,0x1004,0x1008 on consecutive cycles; usage_o never exceeds 1.
2. ready_i=0, single push valid_i=11 (slot0 iaddr=0xA0 itype=1 cause=2 tval=0xDEAD; slot1 iaddr=0xB0 itype=0) → usage_o=2. Then ready_i=1: outputs 0xA0 (cause_o=2, tval_o=0xDEAD), then 0xB0, then valid_o=0.
3. ready_i=0, four pushes of valid_i=11 fill DEPTH=8 → usage_o=8. A fifth push of valid_i=11 → usage_o stays 8; overflow_o=1; dropped_o=2.
4. Full buffer, ready_i=1 and valid_i=01 in the same cycle → block accepted, usage_o stays 8, no drop. Same cycle with valid_i=11 → dropped_o += 2, usage_o=7.
5. Pointer wrap: stream 20 blocks with ready_i toggling 1/0 each cycle → all 20 emerge in order; overflow_o=0.
6. Buffer holding 5 blocks with overflow_o=1: assert flush_i together with valid_i=11 → next cycle usage_o=0, valid_o=0, overflow_o=0, dropped_o=0. Separately, deassert rst_ni mid-stream → outputs 0 immediately.

Source files
------------

// File: rtl/te_block_serializer_if.sv
// Bundles the serializer's data paths: the N-wide group from the multiple-
// retirement block, the single-block valid/ready stream to the trace encoder,
// and the buffer status outputs.
//   master : upstream/encoder side (drives *_i and ready_i, observes *_o)
//   slave  : serializer side (observes *_i and ready_i, drives *_o)
interface te_block_serializer_if #(
   parameter int N           = 2,
   parameter int DEPTH       = 8,
   parameter int CNT_W       = 16,
   parameter int IRETIRE_LEN = 32,
   parameter int ITYPE_LEN   = 3,
   parameter int CAUSE_LEN   = 5,
   parameter int XLEN        = 32,
   parameter int PRIV_LEN    = 2
);
   // parallel input group
   logic [N-1:0]                  valid_i;
   logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
   logic [N-1:0]                  ilastsize_i;
   logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
   logic [N-1:0][CAUSE_LEN-1:0]   cause_i;
   logic [N-1:0][XLEN-1:0]        tval_i;
   logic [N-1:0][PRIV_LEN-1:0]    priv_i;
   logic [N-1:0][XLEN-1:0]        iaddr_i;

   // serial output stream
   logic                          valid_o;
   logic                          ready_i;
   logic [IRETIRE_LEN-1:0]        iretire_o;
   logic                          ilastsize_o;
   logic [ITYPE_LEN-1:0]          itype_o;
   logic [CAUSE_LEN-1:0]          cause_o;
   logic [XLEN-1:0]               tval_o;
   logic [PRIV_LEN-1:0]           priv_o;
   logic [XLEN-1:0]               iaddr_o;

   // status
   logic [$clog2(DEPTH):0]        usage_o;
   logic                          overflow_o;
   logic [CNT_W-1:0]              dropped_o;

   modport master (
      output valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i,
      output ready_i,
      input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
      input  usage_o, overflow_o, dropped_o
   );

   modport slave (
      input  valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i,
      input  ready_i,
      output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
      output usage_o, overflow_o, dropped_o
   );
endinterface

// File: rtl/te_block_serializer.sv
// Trace block serializer. Accepts up to N trace blocks per cycle into a
// circular buffer and replays them one per cycle over valid/ready. A group
// that does not fit is dropped whole; the drop sets a sticky overflow flag
// and adds the group size to a saturating counter.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous clear of buffer, overflow flag and drop counter
//   bus     : te_block_serializer_if.slave (input group, output stream, status)
module te_block_serializer #(
   parameter int N           = 2,
   parameter int DEPTH       = 8,
   parameter int CNT_W       = 16,
   parameter int IRETIRE_LEN = 32,
   parameter int ITYPE_LEN   = 3,
   parameter int CAUSE_LEN   = 5,
   parameter int XLEN        = 32,
   parameter int PRIV_LEN    = 2
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   input logic                  flush_i,
   te_block_serializer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int USE_W = PTR_W + 1;
   localparam int ENT_W = IRETIRE_LEN + 1 + ITYPE_LEN + CAUSE_LEN + XLEN + PRIV_LEN + XLEN;

   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [USE_W-1:0] usage_reg;
   logic             overflow_reg;
   logic [CNT_W-1:0] dropped_reg;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [ENT_W-1:0] entry [N];
   logic [PTR_W-1:0] slot_ofs [N];
   logic [USE_W-1:0] k_cnt;
   logic [USE_W:0]   free_cnt;
   logic [CNT_W:0]   drop_sum;
   logic [ENT_W-1:0] head;
   logic             pop;
   logic             accept;

   // pack each slot into one storage word
   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign entry[gi] = {bus.iretire_i[gi], bus.ilastsize_i[gi], bus.itype_i[gi],
                          bus.cause_i[gi], bus.tval_i[gi], bus.priv_i[gi], bus.iaddr_i[gi]};
   end

   // Each valid slot lands at wr_ptr + (number of valid slots below it), so the
   // group is compacted in ascending slot order.
   always_comb begin
      k_cnt = '0;
      for (int i = 0; i < N; i++) begin
         slot_ofs[i] = k_cnt[PTR_W-1:0];
         k_cnt       = k_cnt + USE_W'(bus.valid_i[i]);
      end
   end

   assign pop      = (usage_reg != '0) && bus.ready_i;
   // a pop in the same cycle frees one slot for the incoming group
   assign free_cnt = (USE_W+1)'(DEPTH) - (USE_W+1)'(usage_reg) + (USE_W+1)'(pop);
   assign accept   = ({1'b0, k_cnt} <= free_cnt);
   assign drop_sum = {1'b0, dropped_reg} + (CNT_W+1)'(k_cnt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         usage_reg    <= '0;
         overflow_reg <= 1'b0;
         dropped_reg  <= '0;
      end else if (flush_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         usage_reg    <= '0;
         overflow_reg <= 1'b0;
         dropped_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
         if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + k_cnt[PTR_W-1:0];
            usage_reg  <= usage_reg + k_cnt - USE_W'(pop);
         end else begin
            usage_reg    <= usage_reg - USE_W'(pop);
            overflow_reg <= 1'b1;
            dropped_reg  <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
         end
      end
   end

   // storage needs no reset: contents are only visible while usage is non-zero
   always_ff @(posedge clk_i) begin
      if (!flush_i && accept) begin
         for (int i = 0; i < N; i++) begin
            if (bus.valid_i[i]) begin
               mem[wr_ptr_reg + slot_ofs[i]] <= entry[i];
            end
         end
      end
   end

   // head is masked to zero while the buffer is empty so stale data never leaks
   assign head        = (usage_reg != '0) ? mem[rd_ptr_reg] : '0;
   assign bus.valid_o = (usage_reg != '0);
   assign {bus.iretire_o, bus.ilastsize_o, bus.itype_o, bus.cause_o,
           bus.tval_o, bus.priv_o, bus.iaddr_o} = head;

   assign bus.usage_o    = usage_reg;
   assign bus.overflow_o = overflow_reg;
   assign bus.dropped_o  = dropped_reg;
endmodule

// File: tb/tb_te_block_serializer.sv
module tb_te_block_serializer;
   localparam int N = 2, DEPTH = 8, CNT_W = 16;
   localparam int IRL = 32, ITL = 3, CL = 5, XL = 32, PL = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   te_block_serializer_if #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W), .IRETIRE_LEN(IRL),
      .ITYPE_LEN(ITL), .CAUSE_LEN(CL), .XLEN(XL), .PRIV_LEN(PL)) bus ();

   te_block_serializer #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W), .IRETIRE_LEN(IRL),
      .ITYPE_LEN(ITL), .CAUSE_LEN(CL), .XLEN(XL), .PRIV_LEN(PL)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus.slave));

   typedef struct {
      logic [63:0] iretire, ilastsize, itype, cause, tval, priv, iaddr;
   } blk_t;

   // reference model: ordered queue of accepted blocks plus status
   blk_t mq[$];
   bit   m_ovf;
   int   m_drop;
   blk_t in_blk[N];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic rand_blocks();
      for (int i = 0; i < N; i++) begin
         in_blk[i].iretire   = 64'($urandom());
         in_blk[i].ilastsize = 64'($urandom_range(0, 1));
         in_blk[i].itype     = 64'($urandom_range(0, 7));
         in_blk[i].cause     = 64'($urandom_range(0, 31));
         in_blk[i].tval      = 64'($urandom());
         in_blk[i].priv      = 64'($urandom_range(0, 3));
         in_blk[i].iaddr     = 64'($urandom() & 32'hFFFF_FFFC);
      end
   endtask

   task automatic check_outputs();
      blk_t e;
      e = '{default: 64'd0};
      if (mq.size() != 0) e = mq[0];
      check("valid_o", 64'(bus.valid_o), 64'(mq.size() != 0));
      check("iaddr_o", 64'(bus.iaddr_o), e.iaddr);
      check("tval_o", 64'(bus.tval_o), e.tval);
      check("cause_o", 64'(bus.cause_o), e.cause);
      check("itype_o", 64'(bus.itype_o), e.itype);
      check("iretire_o", 64'(bus.iretire_o), e.iretire);
      check("ilastsize_o", 64'(bus.ilastsize_o), e.ilastsize);
      check("priv_o", 64'(bus.priv_o), e.priv);
      check("usage_o", 64'(bus.usage_o), 64'(mq.size()));
      check("overflow_o", 64'(bus.overflow_o), 64'(m_ovf));
      check("dropped_o", 64'(bus.dropped_o), 64'(m_drop));
   endtask

   // One cycle: check state at the falling edge, drive the next inputs and
   // advance the model to what the following rising edge should produce.
   task automatic step(input logic [N-1:0] vin, input logic rdy, input logic fl);
      int  k;
      int  free;
      bit  do_pop;
      @(negedge clk);
      check_outputs();
      bus.valid_i = vin;
      bus.ready_i = rdy;
      flush       = fl;
      for (int i = 0; i < N; i++) begin
         bus.iretire_i[i]   = in_blk[i].iretire[IRL-1:0];
         bus.ilastsize_i[i] = in_blk[i].ilastsize[0];
         bus.itype_i[i]     = in_blk[i].itype[ITL-1:0];
         bus.cause_i[i]     = in_blk[i].cause[CL-1:0];
         bus.tval_i[i]      = in_blk[i].tval[XL-1:0];
         bus.priv_i[i]      = in_blk[i].priv[PL-1:0];
         bus.iaddr_i[i]     = in_blk[i].iaddr[XL-1:0];
      end
      if (fl) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
         $display("t=%0t flush", $time);
      end else begin
         k      = $countones(vin);
         do_pop = (mq.size() != 0) && rdy;
         free   = DEPTH - mq.size() + int'(do_pop);
         if (do_pop) begin
            $display("t=%0t pop iaddr=0x%0h usage=%0d", $time, mq[0].iaddr, mq.size());
            void'(mq.pop_front());
         end
         if (k <= free) begin
            for (int i = 0; i < N; i++) if (vin[i]) mq.push_back(in_blk[i]);
         end else begin
            m_ovf  = 1'b1;
            m_drop = (m_drop + k > 65535) ? 65535 : m_drop + k;
            $display("t=%0t drop k=%0d", $time, k);
         end
      end
   endtask

   initial begin
      bus.valid_i = '0; bus.ready_i = 1'b0;
      bus.iretire_i = '0; bus.ilastsize_i = '0; bus.itype_i = '0; bus.cause_i = '0;
      bus.tval_i = '0; bus.priv_i = '0; bus.iaddr_i = '0;
      m_ovf = 1'b0; m_drop = 0;
      rand_blocks();

      // reset state
      repeat (2) @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // single-block stream with ready high
      for (int j = 0; j < 3; j++) begin
         in_blk[0].iaddr = 64'h1000 + 64'(4 * j);
         step(2'b01, 1'b1, 1'b0);
      end
      repeat (2) step(2'b00, 1'b1, 1'b0);

      // two-slot group held, then released in slot order
      rand_blocks();
      in_blk[0].iaddr = 64'hA0; in_blk[0].itype = 64'd1; in_blk[0].cause = 64'd2;
      in_blk[0].tval = 64'hDEAD;
      in_blk[1].iaddr = 64'hB0; in_blk[1].itype = 64'd0;
      step(2'b11, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      repeat (3) step(2'b00, 1'b1, 1'b0);

      // fill to DEPTH, then overflow
      for (int j = 0; j < 5; j++) begin
         rand_blocks();
         step(2'b11, 1'b0, 1'b0);
      end
      step(2'b00, 1'b0, 1'b0);
      check("full_usage", 64'(bus.usage_o), 64'd8);
      check("full_drop", 64'(bus.dropped_o), 64'd2);
      check("full_ovf", 64'(bus.overflow_o), 64'd1);

      // full with simultaneous pop: one block fits, two do not
      rand_blocks();
      step(2'b01, 1'b1, 1'b0);
      rand_blocks();
      step(2'b11, 1'b1, 1'b0);
      step(2'b00, 1'b0, 1'b0);
      check("popfull_usage", 64'(bus.usage_o), 64'd7);
      check("popfull_drop", 64'(bus.dropped_o), 64'd4);

      // flush with a simultaneous group, buffer holding 5 blocks
      repeat (2) step(2'b00, 1'b1, 1'b0);
      rand_blocks();
      step(2'b11, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b0);
      check("flush_usage", 64'(bus.usage_o), 64'd0);
      check("flush_valid", 64'(bus.valid_o), 64'd0);
      check("flush_ovf", 64'(bus.overflow_o), 64'd0);
      check("flush_drop", 64'(bus.dropped_o), 64'd0);

      // pointer wrap: 20 blocks, ready toggling
      for (int c = 0; c < 40; c++) begin
         rand_blocks();
         step((c % 2 == 0) ? 2'b01 : 2'b00, (c % 2 == 0), 1'b0);
      end
      repeat (4) step(2'b00, 1'b1, 1'b0);
      check("wrap_ovf", 64'(bus.overflow_o), 64'd0);
      check("wrap_usage", 64'(bus.usage_o), 64'd0);

      // randomized traffic with phases of heavy and light backpressure
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] v;
         logic r;
         rand_blocks();
         v = N'($urandom_range(0, 3));
         r = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         step(v, r, ($urandom_range(0, 99) == 0));
      end

      // asynchronous reset mid-stream
      rand_blocks();
      step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      @(negedge clk);
      check_outputs();
      #2 rst_n = 1'b0;
      #1;
      mq.delete(); m_ovf = 1'b0; m_drop = 0;
      check("arst_valid", 64'(bus.valid_o), 64'd0);
      check("arst_usage", 64'(bus.usage_o), 64'd0);
      check("arst_iaddr", 64'(bus.iaddr_o), 64'd0);
      bus.valid_i = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rand_blocks();
      step(2'b10, 1'b1, 1'b0);
      repeat (3) step(2'b00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
